// File: rtl/queue_server_if.sv
// Bundle between the ticket queue / teller front-ends and queue_server.
// Stats ports exist only when QUEUE_SERVER_STATS_EN is defined.
interface queue_server_if #(
  parameter int NUM_TELLERS = 4,
  parameter int CNT_W       = 8
);
  logic [CNT_W-1:0]       Current_Client;
  logic [CNT_W-1:0]       Total_Clients;
  logic                   Full;
  logic [NUM_TELLERS-1:0] Teller_Req;
  logic                   Done;
  logic [NUM_TELLERS-1:0] Teller_Grant;
  logic [CNT_W-1:0]       Assigned_Client;
  logic [CNT_W-1:0]       Waiting;
  logic [NUM_TELLERS-1:0] Pending;
  logic                   Ack_Error;
`ifdef QUEUE_SERVER_STATS_EN
  logic [15:0]            Served_Count;
  logic [CNT_W-1:0]       Max_Waiting;
`endif

  modport master (
    output Current_Client, Total_Clients, Full, Teller_Req,
    input  Done, Teller_Grant, Assigned_Client, Waiting, Pending, Ack_Error
`ifdef QUEUE_SERVER_STATS_EN
    , input Served_Count, Max_Waiting
`endif
  );

  modport slave (
    input  Current_Client, Total_Clients, Full, Teller_Req,
    output Done, Teller_Grant, Assigned_Client, Waiting, Pending, Ack_Error
`ifdef QUEUE_SERVER_STATS_EN
    , output Served_Count, Max_Waiting
`endif
  );
endinterface

// File: rtl/queue_server.sv
// Round-robin teller server for the client ticket queue: pulses Done, waits for
// Current_Client to advance, then grants the served ticket. Optional stats: QUEUE_SERVER_STATS_EN.
module queue_server #(
  parameter int NUM_TELLERS = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input logic           Clock,
  input logic           Reset,
  queue_server_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_TELLERS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GRANT} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       ptr, idx, sel, idx_nxt;
  logic [CNT_W-1:0]       ticket, assigned, waiting;
  logic [7:0]             tmo_cnt;
  logic [NUM_TELLERS-1:0] pending, grant, idx_oh;
  logic                   done, ack_err, non_empty;

  // First set bit at or after s, scanning upward with wrap; lowest offset wins.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_TELLERS-1:0] p,
                                            input logic [IDX_W-1:0] s);
    logic [IDX_W-1:0] r;
    r = s;
    for (int k = NUM_TELLERS - 1; k >= 0; k--) begin
      int j;
      j = int'(s) + k;
      if (j >= NUM_TELLERS) j = j - NUM_TELLERS;
      if (p[j]) r = j[IDX_W-1:0];
    end
    return r;
  endfunction

  assign waiting   = bus.Total_Clients - bus.Current_Client;
  assign non_empty = (waiting != '0) || bus.Full;
  assign sel       = pick(pending, ptr);
  assign idx_oh    = NUM_TELLERS'(1) << idx;
  assign idx_nxt   = (int'(idx) == NUM_TELLERS - 1) ? '0 : idx + IDX_W'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      ticket   <= '0;
      tmo_cnt  <= '0;
      pending  <= '0;
      grant    <= '0;
      assigned <= '0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      grant   <= '0;
      pending <= pending | bus.Teller_Req;
      case (state)
        IDLE: if (|pending && non_empty) begin
          idx    <= sel;
          ticket <= bus.Current_Client;
          done   <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.Current_Client != ticket) begin
            // Grant, clear and pointer move together so Pending drops with the grant pulse.
            grant    <= idx_oh;
            assigned <= ticket + CNT_W'(1);
            pending  <= (pending & ~idx_oh) | bus.Teller_Req;
            ptr      <= idx_nxt;
            state    <= GRANT;
          end else if (tmo_cnt == 8'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        GRANT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Done            = done;
  assign bus.Teller_Grant    = grant;
  assign bus.Assigned_Client = assigned;
  assign bus.Waiting         = waiting;
  assign bus.Pending         = pending;
  assign bus.Ack_Error       = ack_err;

`ifdef QUEUE_SERVER_STATS_EN
  logic [15:0]      served;
  logic [CNT_W-1:0] max_wait;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      served   <= '0;
      max_wait <= '0;
    end else begin
      if (|grant && served != 16'hFFFF) served <= served + 16'd1;
      if (waiting > max_wait) max_wait <= waiting;
    end
  end

  assign bus.Served_Count = served;
  assign bus.Max_Waiting  = max_wait;
`endif
endmodule

// File: tb/tb_queue_server.sv
// Directed self-checking bench for queue_server; the bench plays the ticket queue,
// advancing Current_Client by hand after each Done.
module tb_queue_server;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt  = 0;
  int   grant_cnt = 0;
  bit   found;

  queue_server_if #(.NUM_TELLERS(4), .CNT_W(8)) bus ();
  queue_server #(.NUM_TELLERS(4), .ACK_TIMEOUT(15), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle boundary passes through here, so Done/grant pulses are all counted.
  task automatic tick();
    @(negedge Clock);
    if (bus.Done === 1'b1) done_cnt++;
    if (bus.Teller_Grant !== 4'b0000) grant_cnt++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic req(input logic [3:0] r);
    bus.Teller_Req = r;
    tick();
    bus.Teller_Req = 4'b0000;
  endtask

  task automatic wait_done(input string tag, input int bound);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (bus.Done === 1'b1) found = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] g, input logic [7:0] a);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (bus.Teller_Grant !== 4'b0000) found = 1'b1;
    end
    chk({tag, "_grant_seen"}, 32'(found), 32'd1);
    chk({tag, "_grant"}, 32'(bus.Teller_Grant), 32'(g));
    chk({tag, "_assigned"}, 32'(bus.Assigned_Client), 32'(a));
  endtask

  task automatic serve(input string tag, input logic [3:0] g, input logic [7:0] a, input int bound);
    wait_done(tag, bound);
    bus.Current_Client = bus.Current_Client + 8'd1;
    wait_grant(tag, g, a);
  endtask

  initial begin
    bus.Current_Client = 8'd0;
    bus.Total_Clients  = 8'd0;
    bus.Full           = 1'b0;
    bus.Teller_Req     = 4'b0000;

    // Reset state
    do_reset();
    chk("rst_done",     32'(bus.Done), 32'd0);
    chk("rst_grant",    32'(bus.Teller_Grant), 32'd0);
    chk("rst_assigned", 32'(bus.Assigned_Client), 32'd0);
    chk("rst_pending",  32'(bus.Pending), 32'd0);
    chk("rst_ackerr",   32'(bus.Ack_Error), 32'd0);

    // Single request, cycle-exact latency
    bus.Total_Clients = 8'd5;
    tick();
    chk("t1_waiting", 32'(bus.Waiting), 32'd5);
    req(4'b0001);
    chk("t1_pending_c1", 32'(bus.Pending), 32'b0001);
    chk("t1_nodone_c1",  32'(bus.Done), 32'd0);
    tick();
    chk("t1_done_c2", 32'(bus.Done), 32'd1);
    bus.Current_Client = 8'd1;
    tick();
    chk("t1_done_c3",  32'(bus.Done), 32'd0);
    chk("t1_grant_c3", 32'(bus.Teller_Grant), 32'd0);
    tick();
    chk("t1_grant_c4",    32'(bus.Teller_Grant), 32'b0001);
    chk("t1_assigned_c4", 32'(bus.Assigned_Client), 32'd1);
    chk("t1_pending_c4",  32'(bus.Pending), 32'd0);
    tick();
    chk("t1_grant_c5",    32'(bus.Teller_Grant), 32'd0);
    chk("t1_assigned_c5", 32'(bus.Assigned_Client), 32'd1);

    // Three simultaneous requests served round-robin
    do_reset();
    bus.Current_Client = 8'd0;
    bus.Total_Clients  = 8'd10;
    done_cnt = 0;
    req(4'b1011);
    chk("t2_pending", 32'(bus.Pending), 32'b1011);
    serve("t2a", 4'b0001, 8'd1, 6);
    serve("t2b", 4'b0010, 8'd2, 6);
    serve("t2c", 4'b1000, 8'd3, 6);
    for (int i = 0; i < 8; i++) tick();
    chk("t2_done_count", 32'(done_cnt), 32'd3);
    chk("t2_pending_end", 32'(bus.Pending), 32'd0);

    // Empty queue holds a pending request indefinitely
    do_reset();
    bus.Current_Client = 8'd7;
    bus.Total_Clients  = 8'd7;
    done_cnt = 0;
    req(4'b0100);
    for (int i = 0; i < 50; i++) tick();
    chk("t3_no_done",  32'(done_cnt), 32'd0);
    chk("t3_pending",  32'(bus.Pending), 32'b0100);
    chk("t3_waiting0", 32'(bus.Waiting), 32'd0);
    bus.Total_Clients = 8'd8;
    serve("t3", 4'b0100, 8'd8, 2);

    // Counters equal but Full: still non-empty; pointer now past teller 2
    bus.Total_Clients = bus.Current_Client;
    bus.Full = 1'b1;
    req(4'b0001);
    serve("t3full", 4'b0001, 8'd9, 4);
    bus.Full = 1'b0;

    // Counter wrap
    do_reset();
    bus.Current_Client = 8'd255;
    bus.Total_Clients  = 8'd2;
    tick();
    chk("t4_waiting", 32'(bus.Waiting), 32'd3);
    req(4'b0010);
    serve("t4", 4'b0010, 8'd0, 4);

    // Ack timeout
    do_reset();
    bus.Current_Client = 8'd0;
    bus.Total_Clients  = 8'd3;
    grant_cnt = 0;
    done_cnt  = 0;
    req(4'b0100);
    wait_done("t5", 4);
    for (int i = 0; i < 15; i++) tick();
    chk("t5_ackerr_early", 32'(bus.Ack_Error), 32'd0);
    tick();
    chk("t5_ackerr",     32'(bus.Ack_Error), 32'd1);
    chk("t5_no_grant",   32'(grant_cnt), 32'd0);
    chk("t5_pending",    32'(bus.Pending), 32'b0100);
    chk("t5_done_count", 32'(done_cnt), 32'd1);
    tick();
    chk("t5_retry_done", 32'(bus.Done), 32'd1);
    bus.Current_Client = 8'd1;
    wait_grant("t5", 4'b0100, 8'd1);
    chk("t5_ackerr_sticky", 32'(bus.Ack_Error), 32'd1);

    // Reset in the middle of WAIT_ACK
    req(4'b0001);
    wait_done("t6", 4);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk("t6_done",     32'(bus.Done), 32'd0);
    chk("t6_grant",    32'(bus.Teller_Grant), 32'd0);
    chk("t6_assigned", 32'(bus.Assigned_Client), 32'd0);
    chk("t6_pending",  32'(bus.Pending), 32'd0);
    chk("t6_ackerr",   32'(bus.Ack_Error), 32'd0);
    Reset = 1'b0;
    req(4'b0001);
    serve("t6", 4'b0001, 8'd2, 4);
    chk("t6_ackerr_after", 32'(bus.Ack_Error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/queue_server.md
Name: queue_server

Overview:
- Service-side counterpart of the client ticket queue.
- The queue issues tickets on New and advances Current_Client on Done. This block consumes tickets on behalf of NUM_TELLERS service desks.
- Collects teller-ready requests, selects one round-robin, and pulses Done to the queue. Once the queue's Current_Client advances, it grants the served ticket number to that teller.
- Sits between the queue's status outputs and the teller front-ends; flags a queue that fails to acknowledge.

Parameters:
NUM_TELLERS, 4, number of teller request/grant lanes (2..8)
ACK_TIMEOUT, 15, max cycles in WAIT_ACK before declaring Ack_Error (1..255)
CNT_W, 8, width of ticket counters; must match queue Current_Client/Total_Clients

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Current_Client  input  CNT_W  queue's current-client counter
Total_Clients  input  CNT_W  queue's total-clients counter
Full  input  1  queue full flag
Teller_Req  input  NUM_TELLERS  one-cycle pulse per teller: teller ready for next client
Done  output  1  one-cycle pulse to queue: serve next client
Teller_Grant  output  NUM_TELLERS  one-hot, one-cycle pulse: ticket assigned to that teller
Assigned_Client  output  CNT_W  ticket number accompanying Teller_Grant; held until next grant
Waiting  output  CNT_W  Total_Clients - Current_Client, modulo 2^CNT_W, combinational
Pending  output  NUM_TELLERS  registered pending-request bits
Ack_Error  output  1  sticky: queue did not advance Current_Client within ACK_TIMEOUT

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - Done=0, Teller_Grant=0, Assigned_Client=0, Pending=0, Ack_Error=0.
  - State=IDLE, round-robin pointer=0, timeout counter=0.
- Pending:
  - Bit i is set when Teller_Req[i]=1 and cleared when Teller_Grant[i] is issued.
  - A request and a grant on the same bit in the same cycle: the set wins (bit stays 1).
  - Repeated requests while a bit is already set are absorbed.
- Non-empty: Waiting!=0, or Full=1. Full=1 covers the wrap case where the counters are equal but the queue is full.
- FSM states: IDLE, ISSUE, WAIT_ACK, GRANT.
  - IDLE -> ISSUE when Pending!=0 and non-empty.
    - Latch the selected index: first set bit at or after the pointer, scanning upward with wrap.
    - Latch ticket = Current_Client.
  - ISSUE: Done=1 for exactly this cycle; clear the timeout counter; -> WAIT_ACK.
  - WAIT_ACK:
    - Current_Client != latched ticket -> GRANT.
    - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT: set Ack_Error, go to IDLE, issue no grant, leave Pending unchanged.
  - GRANT:
    - Teller_Grant[idx]=1 for one cycle; Assigned_Client = latched ticket + 1 (mod 2^CNT_W), i.e. the ticket now being served.
    - Clear Pending[idx]; pointer = idx+1 mod NUM_TELLERS; -> IDLE.
- Latency: request pulse (cycle 0) -> Pending set (cycle 1) -> ISSUE/Done (cycle 2) -> GRANT no earlier than cycle 4.
- Done is never asserted outside ISSUE; at most one transaction is outstanding.
- Pending!=0 while the queue is empty: stay in IDLE indefinitely; Done is not pulsed.
- Ack_Error remains set until Reset; operation continues normally after the error.
- Pending changes during ISSUE/WAIT_ACK/GRANT are accepted; arbitration uses only the bits sampled in IDLE.

Optional Feature:
- Macro QUEUE_SERVER_STATS_EN.
- Defined: adds output Served_Count (16 bits) and output Max_Waiting (CNT_W).
  - Served_Count: increments on each Teller_Grant, saturates at 16'hFFFF.
  - Max_Waiting: running maximum of Waiting sampled every cycle.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour identical.

Test Plan:
- Reset, then Total_Clients=5, Current_Client=0, pulse Teller_Req=4'b0001 -> Done pulses 1 cycle at cycle 2; model advances Current_Client to 1 -> Teller_Grant=4'b0001, Assigned_Client=1, Pending=0.
- Teller_Req=4'b1011 in one cycle, queue holds 10 clients, model acks each Done in 1 cycle -> grants in order 0001, 0010, 1000; Assigned_Client 1, 2, 3; exactly 3 Done pulses.
- Pending=4'b0100, Total_Clients=Current_Client=7, Full=0 -> no Done for 50 cycles; then Total_Clients=8 -> Done within 2 cycles, grant 4'b0100, Assigned_Client=8.
- Wrap: Current_Client=255, Total_Clients=2, request teller 1 -> Waiting=3, Done; model sets Current_Client=0 -> Assigned_Client=0, grant 4'b0010.
- Model never advances Current_Client after Done -> Ack_Error=1 exactly ACK_TIMEOUT=15 cycles after WAIT_ACK entry, no grant, Pending unchanged; next attempt issues Done again.
- Assert Reset during WAIT_ACK -> next cycle all outputs 0, Ack_Error=0; a later request operates normally from IDLE.
